// File: rtl/note_sequencer_pkg.sv
// note_sequencer_pkg: shared state encodings, entry layout and note limits for the note sequencer
package note_sequencer_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PLAY = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;
  localparam int ENTRY_W  = 15;
  localparam int REST_BIT = 14;
  localparam int NOTE_MSB = 13;
  localparam int NOTE_LSB = 8;
  localparam int DUR_MSB  = 7;
  localparam logic [5:0] NOTE_MAX = 6'd59;
  localparam logic [5:0] NOTE_A4  = 6'd33;
  typedef struct packed {
    logic       rest;
    logic [5:0] note;
    logic [7:0] dur;
  } entry_t;
  function automatic entry_t to_entry(input logic [ENTRY_W-1:0] w);
    return '{rest: w[REST_BIT], note: w[NOTE_MSB:NOTE_LSB], dur: w[DUR_MSB:0]};
  endfunction
endpackage

// File: rtl/note_sequencer_tick_gen.sv
// seq_tick_gen: tempo prescaler, one-cycle tick every TICK_DIV cycles after restart
module seq_tick_gen #(
  parameter int TICK_DIV = 25000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(TICK_DIV - 1);
  // free-running modulo-TICK_DIV counter, realigned to zero by restart
  always_ff @(posedge clk)
    if (reset || restart) cnt <= '0;
    else cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: steps a programmed note table on tempo ticks and drives the tone generator
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int TICK_DIV  = 25000,
  parameter int GAP_TICKS = 10,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic               wr_ready,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  output logic [5:0]         freq_select,
  output logic               gate,
  output logic               note_strobe,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      cur_index
);
  state_t state_q, state_d;
  logic [AW:0] idx_q, idx_d;
  entry_t mem [DEPTH];
  entry_t rd_q;
  logic played_q, rest_q, strobe_q, tick, restart, eos, last_tick, enter_play;
  logic [7:0] cnt_q;
  logic [5:0] note_q;
  assign eos        = rd_q.dur == 8'd0 || idx_q[AW];
  assign last_tick  = tick && cnt_q == 8'd1;
  assign enter_play = state_q == S_LOAD && state_d == S_PLAY;
  assign restart    = state_d != state_q && (state_d == S_PLAY || state_d == S_GAP);
  seq_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );
  // note table: written only while idle, read port registered on the upcoming index
  always_ff @(posedge clk) begin
    if (wr_en && state_q == S_IDLE) mem[wr_addr] <= to_entry(wr_data);
    rd_q <= mem[idx_d[AW-1:0]];
  end
  // state register
  always_ff @(posedge clk)
    if (reset) state_q <= S_IDLE;
    else state_q <= state_d;
  // next-state and next-index; stop overrides every other transition
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        idx_d   = '0;
      end
      S_LOAD: if (eos && loop_en && played_q) begin
        state_d = S_LOAD;
        idx_d   = '0;
      end else state_d = eos ? S_DONE : S_PLAY;
      S_PLAY: if (last_tick) begin
        state_d = GAP_TICKS > 0 ? S_GAP : S_LOAD;
        idx_d   = GAP_TICKS > 0 ? idx_q : idx_q + (AW + 1)'(1);
      end
      S_GAP: if (last_tick) begin
        state_d = S_LOAD;
        idx_d   = idx_q + (AW + 1)'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (stop) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
    end
  end
  // datapath: index, played flag, duration/gap countdown and the latched note
  always_ff @(posedge clk)
    if (reset) begin
      idx_q    <= '0;
      played_q <= 1'b0;
      cnt_q    <= '0;
      note_q   <= '0;
      rest_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      played_q <= state_q == S_IDLE && start ? 1'b0 : played_q | (state_q == S_PLAY);
      cnt_q    <= restart ? (state_d == S_PLAY ? rd_q.dur : 8'(GAP_TICKS)) : tick ? cnt_q - 8'd1 : cnt_q;
      strobe_q <= enter_play;
      if (enter_play) begin
        note_q <= rd_q.note;
        rest_q <= rd_q.rest || rd_q.note > NOTE_MAX;
      end
    end
  // outputs decoded from state and the latched note
  always_comb begin
    freq_select = note_q;
    gate        = state_q == S_PLAY && !rest_q;
    note_strobe = strobe_q;
    busy        = state_q != S_IDLE;
    done        = state_q == S_DONE;
    wr_ready    = state_q == S_IDLE;
    cur_index   = idx_q[AW-1:0];
  end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed scenario checks for note_sequencer with TICK_DIV=4, GAP_TICKS=1, DEPTH=4
module tb_note_sequencer;
  import note_sequencer_pkg::*;
  typedef logic [11:0] obs_t;
  logic clk = 0, reset = 1, wr_en = 0, start = 0, stop = 0, loop_en = 0;
  logic [1:0] wr_addr = '0;
  logic [14:0] wr_data = '0;
  logic wr_ready, gate, note_strobe, busy, done;
  logic [5:0] freq_select;
  logic [1:0] cur_index;
  int passed = 0, total = 0;
  obs_t exp_q[$];
  note_sequencer #(.DEPTH(4), .TICK_DIV(4), .GAP_TICKS(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .start(start), .stop(stop), .loop_en(loop_en),
    .freq_select(freq_select), .gate(gate), .note_strobe(note_strobe),
    .busy(busy), .done(done), .cur_index(cur_index)
  );
  always #5 clk = ~clk;
  function automatic obs_t obs();
    return {gate, freq_select, note_strobe, done, busy, cur_index};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic write(input logic [1:0] a, input logic [14:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    step();
    wr_en = 0;
  endtask
  task automatic add_seg(input int n, input logic g, input logic [5:0] f, input logic s,
                         input logic d, input logic b, input logic [1:0] ix);
    for (int k = 0; k < n; k++) exp_q.push_back({g, f, s && k == 0, d, b, ix});
  endtask
  task automatic pulse_start();
    start = 1;
    step();
    start = 0;
  endtask
  task automatic load_basic();
    write(2'd0, {1'b0, NOTE_A4, 8'd3});
    write(2'd1, {1'b0, 6'd24, 8'd2});
    write(2'd2, 15'd0);
  endtask
  task automatic test_reset();
    total++;
    if (obs() !== 12'd0) $display("FAIL reset_outputs: got %b want %b", obs(), 12'd0);
    else passed++;
    total++;
    if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
    else passed++;
  endtask
  task automatic test_basic();
    load_basic();
    exp_q.delete();
    add_seg(1, 0, 6'd0, 0, 0, 1, 2'd0);
    add_seg(12, 1, 6'd33, 1, 0, 1, 2'd0);
    add_seg(4, 0, 6'd33, 0, 0, 1, 2'd0);
    add_seg(1, 0, 6'd33, 0, 0, 1, 2'd1);
    add_seg(8, 1, 6'd24, 1, 0, 1, 2'd1);
    add_seg(4, 0, 6'd24, 0, 0, 1, 2'd1);
    add_seg(1, 0, 6'd24, 0, 0, 1, 2'd2);
    add_seg(1, 0, 6'd24, 0, 1, 1, 2'd2);
    add_seg(1, 0, 6'd24, 0, 0, 0, 2'd2);
    pulse_start();
    foreach (exp_q[i]) begin
      total++;
      if (obs() !== exp_q[i]) $display("FAIL basic cyc %0d: got %b want %b", i, obs(), exp_q[i]);
      else passed++;
      step();
    end
  endtask
  task automatic test_loop();
    loop_en = 1;
    exp_q.delete();
    add_seg(1, 0, 6'd24, 0, 0, 1, 2'd0);
    for (int p = 0; p < 3; p++) begin
      add_seg(12, 1, 6'd33, 1, 0, 1, 2'd0);
      add_seg(4, 0, 6'd33, 0, 0, 1, 2'd0);
      add_seg(1, 0, 6'd33, 0, 0, 1, 2'd1);
      add_seg(8, 1, 6'd24, 1, 0, 1, 2'd1);
      add_seg(4, 0, 6'd24, 0, 0, 1, 2'd1);
      add_seg(1, 0, 6'd24, 0, 0, 1, 2'd2);
      add_seg(1, 0, 6'd24, 0, 0, 1, 2'd0);
    end
    pulse_start();
    foreach (exp_q[i]) begin
      total++;
      if (obs() !== exp_q[i]) $display("FAIL loop cyc %0d: got %b want %b", i, obs(), exp_q[i]);
      else passed++;
      step();
    end
    total++;
    if (obs() !== {1'b1, 6'd33, 1'b1, 1'b0, 1'b1, 2'd0})
      $display("FAIL loop_restart_strobe: got %b want %b", obs(), {1'b1, 6'd33, 1'b1, 1'b0, 1'b1, 2'd0});
    else passed++;
    stop = 1;
    step();
    stop = 0;
    loop_en = 0;
    total++;
    if (obs() !== {1'b0, 6'd33, 1'b0, 1'b0, 1'b0, 2'd0})
      $display("FAIL loop_stop: got %b want %b", obs(), {1'b0, 6'd33, 1'b0, 1'b0, 1'b0, 2'd0});
    else passed++;
  endtask
  task automatic test_stop();
    pulse_start();
    for (int k = 0; k < 5; k++) step();
    stop = 1;
    step();
    stop = 0;
    total++;
    if (obs() !== {1'b0, 6'd33, 1'b0, 1'b0, 1'b0, 2'd0})
      $display("FAIL stop_mid_note: got %b want %b", obs(), {1'b0, 6'd33, 1'b0, 1'b0, 1'b0, 2'd0});
    else passed++;
    pulse_start();
    total++;
    if (obs() !== {1'b0, 6'd33, 1'b0, 1'b0, 1'b1, 2'd0})
      $display("FAIL stop_restart_load: got %b want %b", obs(), {1'b0, 6'd33, 1'b0, 1'b0, 1'b1, 2'd0});
    else passed++;
    step();
    total++;
    if (obs() !== {1'b1, 6'd33, 1'b1, 1'b0, 1'b1, 2'd0})
      $display("FAIL stop_restart_play: got %b want %b", obs(), {1'b1, 6'd33, 1'b1, 1'b0, 1'b1, 2'd0});
    else passed++;
    stop = 1;
    step();
    stop = 0;
  endtask
  task automatic test_rests();
    write(2'd0, {1'b1, NOTE_A4, 8'd2});
    write(2'd1, {1'b0, 6'd61, 8'd2});
    write(2'd2, 15'd0);
    exp_q.delete();
    add_seg(1, 0, 6'd33, 0, 0, 1, 2'd0);
    add_seg(8, 0, 6'd33, 1, 0, 1, 2'd0);
    add_seg(4, 0, 6'd33, 0, 0, 1, 2'd0);
    add_seg(1, 0, 6'd33, 0, 0, 1, 2'd1);
    add_seg(8, 0, 6'd61, 1, 0, 1, 2'd1);
    add_seg(4, 0, 6'd61, 0, 0, 1, 2'd1);
    add_seg(1, 0, 6'd61, 0, 0, 1, 2'd2);
    add_seg(1, 0, 6'd61, 0, 1, 1, 2'd2);
    add_seg(1, 0, 6'd61, 0, 0, 0, 2'd2);
    pulse_start();
    foreach (exp_q[i]) begin
      total++;
      if (obs() !== exp_q[i]) $display("FAIL rests cyc %0d: got %b want %b", i, obs(), exp_q[i]);
      else passed++;
      step();
    end
  endtask
  task automatic test_empty();
    write(2'd0, 15'd0);
    loop_en = 1;
    exp_q.delete();
    add_seg(1, 0, 6'd61, 0, 0, 1, 2'd0);
    add_seg(1, 0, 6'd61, 0, 1, 1, 2'd0);
    add_seg(2, 0, 6'd61, 0, 0, 0, 2'd0);
    pulse_start();
    foreach (exp_q[i]) begin
      total++;
      if (obs() !== exp_q[i]) $display("FAIL empty cyc %0d: got %b want %b", i, obs(), exp_q[i]);
      else passed++;
      step();
    end
    loop_en = 0;
  endtask
  task automatic test_busy();
    load_basic();
    pulse_start();
    step();
    total++;
    if (wr_ready !== 1'b0) $display("FAIL busy_wr_ready: got %b want 0", wr_ready);
    else passed++;
    write(2'd0, {1'b0, 6'd50, 8'd1});
    stop = 1;
    step();
    stop = 0;
    pulse_start();
    step();
    total++;
    if (obs() !== {1'b1, 6'd33, 1'b1, 1'b0, 1'b1, 2'd0})
      $display("FAIL busy_write_ignored: got %b want %b", obs(), {1'b1, 6'd33, 1'b1, 1'b0, 1'b1, 2'd0});
    else passed++;
    step();
    reset = 1;
    step();
    reset = 0;
    total++;
    if ({obs(), wr_ready} !== 13'd1)
      $display("FAIL busy_reset: got %b want %b", {obs(), wr_ready}, 13'd1);
    else passed++;
    pulse_start();
    step();
    total++;
    if (obs() !== {1'b1, 6'd33, 1'b1, 1'b0, 1'b1, 2'd0})
      $display("FAIL reset_keeps_table: got %b want %b", obs(), {1'b1, 6'd33, 1'b1, 1'b0, 1'b1, 2'd0});
    else passed++;
    stop = 1;
    step();
    start = 1;
    step();
    start = 0;
    stop = 0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({busy, wr_ready, gate} !== 3'b010)
        $display("FAIL start_stop_same_cycle %0d: got %b want %b", k, {busy, wr_ready, gate}, 3'b010);
      else passed++;
      step();
    end
  endtask
  initial begin
    for (int k = 0; k < 3; k++) step();
    reset = 0;
    test_reset();
    test_basic();
    test_loop();
    test_stop();
    test_rests();
    test_empty();
    test_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
